// File: rtl/pcileech_com_pkg.sv
// Shared definitions for the RX word demultiplexer: magic value, in_data
// field positions, target encoding and TLP framing FSM states.
package pcileech_com_pkg;

    localparam logic [7:0] RX_MAGIC = 8'h77;

    localparam int DW_HI    = 63;
    localparam int DW_LO    = 32;
    localparam int MAGIC_HI = 7;
    localparam int MAGIC_LO = 0;
    localparam int TGT_HI   = 9;
    localparam int TGT_LO   = 8;
    localparam int LAST_BIT = 12;

    typedef enum logic [1:0] {
        TGT_TLP = 2'd0,
        TGT_LB  = 2'd1,
        TGT_CFG = 2'd2,
        TGT_CMD = 2'd3
    } tgt_e;

    typedef enum logic [1:0] {
        TLP_IDLE    = 2'd0,
        TLP_FRAME   = 2'd1,
        TLP_DISCARD = 2'd2,
        TLP_TERM    = 2'd3
    } tlp_state_e;

    // TLP FIFO entry layout: {abort, last, dw}
    localparam int TLP_FIFO_W = 34;

endpackage

// File: rtl/pcileech_rx_demux_fifo.sv
// Synchronous first-word-fall-through FIFO. A write while full is ignored;
// a same-cycle read never makes room for that cycle's write.
module pcileech_rx_demux_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    output logic             full,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready
);
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);

    logic [WIDTH-1:0]      mem [1 << DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_wr;
    logic                  do_rd;

    assign full     = (count == FULL_CNT);
    assign rd_valid = (count != '0);
    assign do_wr    = wr_en && !full;
    assign do_rd    = rd_valid && rd_ready;
    // Gate with valid so the output reads zero whenever the FIFO is empty
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pcileech_com_rx_demux.sv
// Routes magic-checked RX words to four buffered target streams; every TLP
// frame that got a word into its FIFO is closed by last or by an abort entry.
module pcileech_com_rx_demux
    import pcileech_com_pkg::*;
#(
    parameter int DEPTH_LOG2  = 4,
    parameter int TLP_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] in_data,
    input  logic        in_valid,
    output logic [31:0] tlp_data,
    output logic        tlp_last,
    output logic        tlp_abort,
    output logic        tlp_valid,
    input  logic        tlp_ready,
    output logic [31:0] lb_data,
    output logic        lb_valid,
    input  logic        lb_ready,
    output logic [63:0] cfg_data,
    output logic        cfg_valid,
    input  logic        cfg_ready,
    output logic [63:0] cmd_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [15:0] drop_cnt,
    output logic [15:0] bad_magic_cnt
);
    localparam int STAGES = 1;
    localparam logic [15:0] TO_LAST = 16'(TLP_TIMEOUT - 1);

    logic [STAGES:0] vld_pipe;
    logic [63:0]     s0_data;

    assign vld_pipe[0] = in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe[STAGES:1] <= '0;
            s0_data            <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            s0_data            <= in_data;
        end
    end

    logic        s0_valid;
    logic        magic_ok;
    logic        word_ok;
    tgt_e        tgt;
    logic        s0_last;
    logic [31:0] s0_dw;

    assign s0_valid = vld_pipe[STAGES];
    assign magic_ok = (s0_data[MAGIC_HI:MAGIC_LO] == RX_MAGIC);
    assign word_ok  = s0_valid && magic_ok;
    assign tgt      = tgt_e'(s0_data[TGT_HI:TGT_LO]);
    assign s0_last  = s0_data[LAST_BIT];
    assign s0_dw    = s0_data[DW_HI:DW_LO];

    logic tlp_word;
    logic lb_we;
    logic cfg_we;
    logic cmd_we;
    logic tlp_full;
    logic lb_full;
    logic cfg_full;
    logic cmd_full;

    assign tlp_word = word_ok && (tgt == TGT_TLP);
    assign lb_we    = word_ok && (tgt == TGT_LB);
    assign cfg_we   = word_ok && (tgt == TGT_CFG);
    assign cmd_we   = word_ok && (tgt == TGT_CMD);

    tlp_state_e            tlp_state;
    logic [15:0]           tlp_timer;
    logic                  tlp_we;
    logic                  tlp_drop;
    logic [TLP_FIFO_W-1:0] tlp_wdata;

    // In TERM the incoming TLP word is lost; the slot goes to the terminator
    always_comb begin
        tlp_we    = 1'b0;
        tlp_drop  = 1'b0;
        tlp_wdata = {1'b0, s0_last, s0_dw};
        case (tlp_state)
            TLP_IDLE, TLP_FRAME: begin
                tlp_we   = tlp_word && !tlp_full;
                tlp_drop = tlp_word && tlp_full;
            end
            TLP_DISCARD: tlp_drop = tlp_word;
            TLP_TERM: begin
                tlp_we    = !tlp_full;
                tlp_wdata = {1'b1, 1'b1, 32'h0};
                tlp_drop  = tlp_word;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tlp_state <= TLP_IDLE;
            tlp_timer <= '0;
        end else begin
            case (tlp_state)
                TLP_IDLE: begin
                    tlp_timer <= '0;
                    if (tlp_word && !s0_last)
                        tlp_state <= tlp_full ? TLP_DISCARD : TLP_FRAME;
                end
                TLP_FRAME, TLP_DISCARD: begin
                    if (tlp_word) begin
                        tlp_timer <= '0;
                        if (tlp_state == TLP_DISCARD || tlp_full)
                            tlp_state <= s0_last ? TLP_TERM : TLP_DISCARD;
                        else if (s0_last)
                            tlp_state <= TLP_IDLE;
                    end else if (tlp_timer == TO_LAST) begin
                        tlp_timer <= '0;
                        tlp_state <= TLP_TERM;
                    end else begin
                        tlp_timer <= tlp_timer + 16'd1;
                    end
                end
                TLP_TERM: begin
                    tlp_timer <= '0;
                    if (!tlp_full)
                        tlp_state <= TLP_IDLE;
                end
                default: tlp_state <= TLP_IDLE;
            endcase
        end
    end

    logic drop_evt;
    logic bad_evt;

    assign drop_evt = tlp_drop || (lb_we && lb_full) || (cfg_we && cfg_full) || (cmd_we && cmd_full);
    assign bad_evt  = s0_valid && !magic_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt      <= '0;
            bad_magic_cnt <= '0;
        end else begin
            if (drop_evt && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
            if (bad_evt && bad_magic_cnt != 16'hFFFF)
                bad_magic_cnt <= bad_magic_cnt + 16'd1;
        end
    end

    logic [TLP_FIFO_W-1:0] tlp_q;

    assign tlp_data  = tlp_q[31:0];
    assign tlp_last  = tlp_q[32];
    assign tlp_abort = tlp_q[33];

    pcileech_rx_demux_fifo #(.WIDTH(TLP_FIFO_W), .DEPTH_LOG2(DEPTH_LOG2)) u_tlp_fifo (
        .clk(clk), .rst(rst), .wr_data(tlp_wdata), .wr_en(tlp_we), .full(tlp_full),
        .rd_data(tlp_q), .rd_valid(tlp_valid), .rd_ready(tlp_ready)
    );

    pcileech_rx_demux_fifo #(.WIDTH(32), .DEPTH_LOG2(DEPTH_LOG2)) u_lb_fifo (
        .clk(clk), .rst(rst), .wr_data(s0_dw), .wr_en(lb_we), .full(lb_full),
        .rd_data(lb_data), .rd_valid(lb_valid), .rd_ready(lb_ready)
    );

    pcileech_rx_demux_fifo #(.WIDTH(64), .DEPTH_LOG2(DEPTH_LOG2)) u_cfg_fifo (
        .clk(clk), .rst(rst), .wr_data(s0_data), .wr_en(cfg_we), .full(cfg_full),
        .rd_data(cfg_data), .rd_valid(cfg_valid), .rd_ready(cfg_ready)
    );

    pcileech_rx_demux_fifo #(.WIDTH(64), .DEPTH_LOG2(DEPTH_LOG2)) u_cmd_fifo (
        .clk(clk), .rst(rst), .wr_data(s0_data), .wr_en(cmd_we), .full(cmd_full),
        .rd_data(cmd_data), .rd_valid(cmd_valid), .rd_ready(cmd_ready)
    );

endmodule
